// File: rtl/infoframe_builder.sv
// -----------------------------------------------------------------------------
// infoframe_builder
//   Programmable HDMI InfoFrame source. Payload bytes are written into a shadow
//   buffer; a commit pulse starts a serial checksum (one byte per clock). The
//   finished frame is swapped into the active registers only at a packet
//   boundary (pkt_done) or immediately when no frame is valid yet, so the
//   scheduler never sees a half-updated packet.
//
// Ports
//   clk          system / pixel clock
//   rst_n        asynchronous active-low reset
//   wr_en        payload byte write strobe
//   wr_addr      payload byte index PBn, n = 1..IF_LENGTH
//   wr_data      payload byte value
//   commit       pulse: build a frame from the shadow buffer
//   pkt_done     pulse: current InfoFrame packet fully transmitted
//   busy         high from accepted commit until the swap completes
//   frame_valid  active header/sub hold a valid frame
//   header       {3'b0, IF_LENGTH[4:0], IF_VERSION, IF_TYPE}
//   sub          sub[i*56+:56] = {PB[7i+6]..PB[7i]}, PB0 = checksum
// -----------------------------------------------------------------------------
module infoframe_builder #(
    parameter logic [7:0] IF_TYPE    = 8'h84,
    parameter logic [7:0] IF_VERSION = 8'h01,
    parameter int         IF_LENGTH  = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [7:0]   wr_data,
    input  logic         commit,
    input  logic         pkt_done,
    output logic         busy,
    output logic         frame_valid,
    output logic [23:0]  header,
    output logic [223:0] sub
);

    localparam logic [4:0] LEN5    = 5'(IF_LENGTH);
    localparam logic [7:0] HB2     = {3'b000, LEN5};
    localparam logic [7:0] HDR_SUM = IF_TYPE + IF_VERSION + HB2;

    typedef enum logic [1:0] {IDLE, SUM, CSUM, PEND} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  shadow_reg [1:IF_LENGTH];
    logic [7:0]  active_reg [0:IF_LENGTH];
    logic [7:0]  acc_reg;
    logic [7:0]  chk_reg;
    logic [4:0]  idx_reg;
    logic        frame_valid_reg;
    logic [7:0]  shadow_sel;
    logic        accept_commit;
    logic        swap;

    assign accept_commit = (state_reg == IDLE) && commit;
    // With no valid frame on air there is no packet boundary to wait for.
    assign swap = (state_reg == PEND) && (pkt_done || !frame_valid_reg);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (commit)            state_next = SUM;
            SUM:  if (idx_reg == LEN5)   state_next = CSUM;
            CSUM:                        state_next = PEND;
            PEND: if (swap)              state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_reg != IDLE);
    end

    // Shadow byte selected by the running index (decoded mux keeps the
    // index width independent of the array bounds).
    always_comb begin
        shadow_sel = 8'h00;
        for (int i = 1; i <= IF_LENGTH; i++) begin
            if (idx_reg == 5'(i)) begin
                shadow_sel = shadow_reg[i];
            end
        end
    end

    // ---------------- Checksum datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= 8'h00;
            idx_reg <= 5'd0;
            chk_reg <= 8'h00;
        end else begin
            if (accept_commit) begin
                acc_reg <= HDR_SUM;
                idx_reg <= 5'd1;
            end else if (state_reg == SUM) begin
                acc_reg <= acc_reg + shadow_sel;
                idx_reg <= idx_reg + 5'd1;
            end
            if (state_reg == CSUM) begin
                chk_reg <= (~acc_reg) + 8'd1;
            end
        end
    end

    // ---------------- Shadow buffer (writes locked while building) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= IF_LENGTH; i++) begin
                shadow_reg[i] <= 8'h00;
            end
        end else if (wr_en && !busy) begin
            for (int i = 1; i <= IF_LENGTH; i++) begin
                if (wr_addr == 5'(i)) begin
                    shadow_reg[i] <= wr_data;
                end
            end
        end
    end

    // ---------------- Active frame: changes only on swap ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= IF_LENGTH; i++) begin
                active_reg[i] <= 8'h00;
            end
            frame_valid_reg <= 1'b0;
        end else if (swap) begin
            active_reg[0] <= chk_reg;
            for (int i = 1; i <= IF_LENGTH; i++) begin
                active_reg[i] <= shadow_reg[i];
            end
            frame_valid_reg <= 1'b1;
        end
    end

    assign frame_valid = frame_valid_reg;
    assign header      = {3'b000, LEN5, IF_VERSION, IF_TYPE};

    // Bytes past the programmed length are hard zero.
    for (genvar gi = 0; gi < 28; gi++) begin : g_sub
        if (gi <= IF_LENGTH) begin : g_used
            assign sub[gi*8 +: 8] = active_reg[gi];
        end else begin : g_zero
            assign sub[gi*8 +: 8] = 8'h00;
        end
    end

endmodule

// File: tb/tb_infoframe_builder.sv
module tb_infoframe_builder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic [4:0]   wr_addr = 5'd0;
    logic [7:0]   wr_data = 8'h00;
    logic         commit = 1'b0;
    logic         pkt_done = 1'b0;
    logic         busy;
    logic         frame_valid;
    logic [23:0]  header;
    logic [223:0] sub;

    infoframe_builder dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .pkt_done(pkt_done),
        .busy(busy), .frame_valid(frame_valid), .header(header), .sub(sub)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [223:0] exp_q [$];
    string        name_q [$];
    logic [7:0]   model [1:10];
    logic [223:0] cur_frame = '0;

    // Frame expected from the bench's own copy of the legal writes.
    function automatic logic [223:0] model_frame();
        logic [7:0]   s;
        logic [223:0] f;
        s = 8'h8F;  // 0x84 + 0x01 + 0x0A
        f = '0;
        for (int i = 1; i <= 10; i++) begin
            s = s + model[i];
            f[i*8 +: 8] = model[i];
        end
        f[7:0] = (~s) + 8'd1;
        return f;
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", nm, act);
        end
    endtask

    // Monitor: every completed swap is compared against the scoreboard.
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        logic [223:0] e;
        string        n;
        if (rst_n && busy_prev && !busy) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL swap_unexpected: sub %0h with no expected frame", sub);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (sub !== e || frame_valid !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL %s: sub %0h valid %0b expected sub %0h valid 1",
                             n, sub, frame_valid, e);
                end else begin
                    $display("[TB] ok %s swap sub=%0h", n, sub);
                    cur_frame = e;
                end
            end
        end
        busy_prev = rst_n ? busy : 1'b0;
    end

    task automatic write_pb(input logic [4:0] a, input logic [7:0] d, input bit legal);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (legal) model[a] = d;
    endtask

    task automatic pulse_done();
        @(negedge clk); pkt_done = 1'b1;
        @(negedge clk); pkt_done = 1'b0;
    endtask

    task automatic wait_idle(input string nm, output int cyc);
        cyc = 0;
        while (busy && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (busy) begin
            tests++; fails++;
            $display("[TB] FAIL %s_timeout: busy still 1 after %0d cycles, expected 0", nm, cyc);
        end
    endtask

    // Commit, optionally release the boundary with pkt_done, wait for the swap.
    task automatic run_build(input string nm, input logic [223:0] exp,
                             input bit need_done, output int cyc);
        @(negedge clk);
        commit = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        commit = 1'b0;
        if (need_done) begin
            repeat (15) @(negedge clk);
            check({nm, "_pend_busy"}, 256'(busy), 256'd1);
            check({nm, "_pend_sub"}, 256'(sub), 256'(cur_frame));
            pulse_done();
        end
        wait_idle(nm, cyc);
    endtask

    initial begin
        int cyc;
        int bad;
        for (int i = 1; i <= 10; i++) model[i] = 8'h00;

        // Reset state
        #1;
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_valid", 256'(frame_valid), 256'd0);
        check("rst_sub", 256'(sub), 256'd0);
        check("rst_header", 256'(header), 256'h0A0184);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1. Defaults, latency with no valid frame
        write_pb(5'd1, 8'h01, 1'b1);
        run_build("t1_default", 224'h0170, 1'b0, cyc);
        check("t1_latency", 256'(cyc), 256'd12);
        check("t1_valid", 256'(frame_valid), 256'd1);
        check("t1_header", 256'(header), 256'h0A0184);

        // 2. Wrap-around checksum
        for (int i = 1; i <= 10; i++) write_pb(5'(i), 8'hFF, 1'b1);
        run_build("t2_wrap", 224'hFFFFFFFFFFFFFFFFFFFF7B, 1'b1, cyc);

        // 3. Live update held until the packet boundary
        write_pb(5'd4, 8'h13, 1'b1);
        @(negedge clk);
        commit = 1'b1;
        exp_q.push_back(model_frame());
        name_q.push_back("t3_live");
        @(negedge clk);
        commit = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!busy || sub !== cur_frame) bad++;
        end
        check("t3_hold_violations", 256'(bad), 256'd0);
        pulse_done();
        wait_idle("t3_live", cyc);
        check("t3_hand", 256'(sub[39:32]), 256'h13);
        check("t3_chk", 256'(sub[7:0]), 256'h67);

        // 4. Illegal accesses are dropped
        write_pb(5'd0, 8'h55, 1'b0);
        write_pb(5'd11, 8'h66, 1'b0);
        write_pb(5'd31, 8'h77, 1'b0);
        write_pb(5'd1, 8'h22, 1'b1);
        @(negedge clk);
        commit = 1'b1;
        exp_q.push_back(model_frame());
        name_q.push_back("t4_illegal");
        @(negedge clk);
        commit = 1'b0;
        write_pb(5'd2, 8'hAA, 1'b0);  // while busy
        repeat (12) @(negedge clk);
        pulse_done();
        wait_idle("t4_illegal", cyc);

        // 5. commit and pkt_done in the same idle cycle
        write_pb(5'd5, 8'h01, 1'b1);
        @(negedge clk);
        commit = 1'b1; pkt_done = 1'b1;
        exp_q.push_back(model_frame());
        name_q.push_back("t5_simul");
        @(negedge clk);
        commit = 1'b0; pkt_done = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_still_busy", 256'(busy), 256'd1);
        check("t5_sub_held", 256'(sub), 256'(cur_frame));
        pulse_done();
        wait_idle("t5_simul", cyc);

        // 6. Reset mid-SUM aborts the build
        write_pb(5'd6, 8'h44, 1'b1);
        @(negedge clk);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", 256'(busy), 256'd0);
        check("t6_rst_valid", 256'(frame_valid), 256'd0);
        check("t6_rst_sub", 256'(sub), 256'd0);
        for (int i = 1; i <= 10; i++) model[i] = 8'h00;
        cur_frame = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        write_pb(5'd3, 8'h5A, 1'b1);
        run_build("t6_fresh", 224'h5A000017, 1'b0, cyc);
        check("t6_latency", 256'(cyc), 256'd12);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 256'(exp_q.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
